alu_div: RTL

//  Iterative multi-cycle signed/unsigned 16-bit divider; the inverse companion of the ALU's single-cycle MUL.

---
 rtl/alu_div_pkg.sv | 14 +
 rtl/alu_div_step.sv | 23 ++
 rtl/alu_div.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/alu_div_pkg.sv
// Shared types and decode constants for the iterative divider beside the EX-stage ALU.
package alu_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } div_state_e;

  // Func codes the decoder uses to start a divide and pick quot or rem for the EX_DM write.
  localparam logic [5:0] FuncDiv = 6'h1a;
  localparam logic [5:0] FuncRem = 6'h1b;

endpackage

// File: rtl/alu_div_step.sv
// One restoring-division step: shift the next dividend bit into R, subtract D when it fits.
module alu_div_step #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] r_i,
  input  logic [DATA_W-1:0] q_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] r_o,
  output logic [DATA_W-1:0] q_o
);

  // Extra bit keeps the shifted remainder exact when D is as large as 0x8000 or above.
  logic [DATA_W:0] r_shift;
  logic            fits;

  always_comb begin
    r_shift = {r_i, q_i[DATA_W-1]};
    fits    = (r_shift >= {1'b0, d_i});
    r_o     = fits ? DATA_W'(r_shift - {1'b0, d_i}) : r_shift[DATA_W-1:0];
    q_o     = {q_i[DATA_W-2:0], fits};
  end

endmodule

// File: rtl/alu_div.sv
// Multi-cycle signed/unsigned divider; stalls the front end while busy and returns
// saturated quotient, remainder and ov/zr/neg flags on a one-cycle done pulse.
module alu_div
  import alu_div_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              op_signed,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src0,
  output logic              busy,
  output logic              stall_req,
  output logic              done,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem,
  output logic              ov,
  output logic              zr,
  output logic              neg
);

  localparam int unsigned        CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0]    CntLast = CntW'(DATA_W - 1);
  localparam logic [DATA_W-1:0]  MinNeg  = {1'b1, {(DATA_W - 1){1'b0}}};
  localparam logic [DATA_W-1:0]  MaxPos  = ~MinNeg;

  div_state_e        state_q, state_d;
  logic              load, step_en, fix;

  logic [CntW-1:0]   cnt_q;
  logic [DATA_W-1:0] part_rem_q, part_quot_q, divisor_q, dividend_q;
  logic              signed_op_q, quot_neg_q, rem_neg_q;

  logic [DATA_W-1:0] quot_q, rem_q;
  logic              ov_q, zr_q;

  logic              src1_neg, src0_neg;
  logic [DATA_W-1:0] src1_mag, src0_mag;
  logic [DATA_W-1:0] step_rem, step_quot;
  logic [DATA_W-1:0] fix_quot, fix_rem;
  logic              fix_ov;

  alu_div_step #(
    .DATA_W (DATA_W)
  ) u_step (
    .r_i (part_rem_q),
    .q_i (part_quot_q),
    .d_i (divisor_q),
    .r_o (step_rem),
    .q_o (step_quot)
  );

  always_comb begin
    src1_neg = op_signed & src1[DATA_W-1];
    src0_neg = op_signed & src0[DATA_W-1];
    src1_mag = src1_neg ? -src1 : src1;
    src0_mag = src0_neg ? -src0 : src0;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step_en = 1'b0;
    fix     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        step_en = 1'b1;
        if (cnt_q == '0) state_d = StFix;
      end
      StFix: begin
        fix     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A positive signed quotient with the sign bit set can only be 0x8000 / -1.
  always_comb begin
    fix_ov   = 1'b1;
    fix_quot = MaxPos;
    fix_rem  = '0;
    if (divisor_q == '0) begin
      fix_rem = dividend_q;
      if (!signed_op_q) begin
        fix_quot = '1;
      end else if (dividend_q[DATA_W-1]) begin
        fix_quot = MinNeg;
      end
    end else if (!(signed_op_q && !quot_neg_q && part_quot_q[DATA_W-1])) begin
      fix_ov   = 1'b0;
      fix_quot = quot_neg_q ? -part_quot_q : part_quot_q;
      fix_rem  = rem_neg_q ? -part_rem_q : part_rem_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      part_rem_q  <= '0;
      part_quot_q <= '0;
      divisor_q   <= '0;
      dividend_q  <= '0;
      signed_op_q <= 1'b0;
      quot_neg_q  <= 1'b0;
      rem_neg_q   <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      ov_q        <= 1'b0;
      zr_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cnt_q       <= CntLast;
        part_rem_q  <= '0;
        part_quot_q <= src1_mag;
        divisor_q   <= src0_mag;
        dividend_q  <= src1;
        signed_op_q <= op_signed;
        quot_neg_q  <= src1_neg ^ src0_neg;
        rem_neg_q   <= src1_neg;
      end else if (step_en) begin
        cnt_q       <= cnt_q - CntW'(1);
        part_rem_q  <= step_rem;
        part_quot_q <= step_quot;
      end
      if (fix) begin
        quot_q <= fix_quot;
        rem_q  <= fix_rem;
        ov_q   <= fix_ov;
        zr_q   <= (fix_quot == '0);
      end
    end
  end

  // Results go out combinationally in the done cycle and are held afterwards.
  always_comb begin
    busy      = (state_q != StIdle);
    stall_req = start | busy;
    done      = fix;
    quot      = fix ? fix_quot : quot_q;
    rem       = fix ? fix_rem : rem_q;
    ov        = fix ? fix_ov : ov_q;
    zr        = fix ? (fix_quot == '0) : zr_q;
    neg       = quot[DATA_W-1];
  end

endmodule
